// File: rtl/fetch_if.sv
// Fetch-stage bundle: decoder control in, ROM address out, ROM word in, decoded word out.
// The master side is the fetch unit; the slave side is the decoder/ROM environment.
interface fetch_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8
);
  logic                   Stall;
  logic                   Redirect_En;
  logic [PC_WIDTH-1:0]    Redirect_Target;
  logic [PC_WIDTH-1:0]    Address;
  logic [INSTR_WIDTH-1:0] Instruction;
  logic [INSTR_WIDTH-1:0] Instr_Out;
  logic                   Instr_Valid;
  logic [PC_WIDTH-1:0]    Instr_PC;
  logic [PC_WIDTH-1:0]    PC_Plus1;
  logic                   Halted;

  modport master (
    input  Stall, Redirect_En, Redirect_Target, Instruction,
    output Address, Instr_Out, Instr_Valid, Instr_PC, PC_Plus1, Halted
  );

  modport slave (
    output Stall, Redirect_En, Redirect_Target, Instruction,
    input  Address, Instr_Out, Instr_Valid, Instr_PC, PC_Plus1, Halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch for the 8-bit unicycle MIPS core: owns the PC, hides the ROM's
// one-cycle read latency, and handles stall, redirect-with-squash and halt.
module fetch_unit #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 8'b11100000
) (
  input logic   Clock,
  input logic   Reset,
  fetch_if.master bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                pend_valid_q, pend_valid_d;
  logic [0:0]          state_q, state_d;

  logic running;
  assign running = (state_q == ST_RUN);

  // Pend_PC is the address of the word the ROM is currently presenting.
  assign bus.Address     = (bus.Stall && !bus.Redirect_En && running) ? pend_pc_q : pc_q;
  assign bus.Instr_Out   = bus.Instruction;
  assign bus.Instr_Valid = pend_valid_q && running;
  assign bus.Instr_PC    = pend_pc_q;
  assign bus.PC_Plus1    = pend_pc_q + PC_ONE;
  assign bus.Halted      = (state_q == ST_HALTED);

  always_comb begin
    // NOTE: every next-state value gets a hold default first so no path infers a latch.
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    state_d      = state_q;

    if (running) begin
      if (bus.Redirect_En) begin
        // The word captured by the ROM on this edge is wrong-path.
        pc_d         = bus.Redirect_Target;
        pend_valid_d = 1'b0;
      end else if (bus.Stall) begin
        pc_d = pc_q;
      end else if (pend_valid_q && (bus.Instruction == HALT_WORD)) begin
        state_d      = ST_HALTED;
        pend_valid_d = 1'b0;
      end else begin
        pend_pc_d    = pc_q;
        pend_valid_d = 1'b1;
        pc_d         = pc_q + PC_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      state_q      <= state_d;
    end
  end

endmodule
